button_debounce: RTL and testbench
==================================

BUTTON_DEBOUNCE -- requirements
Module: button_debounce

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, SHALL set the number of consecutive stable synchronized samples needed to accept a level change (legal range 2..2^20).
REQ-002 Parameter LONG_PRESS_CYCLES, default 50000000, SHALL set the cycles in PRESSED before long_pulse fires (legal range 2..2^28; used only with LONG_PRESS_EN).
REQ-003 Port clk, input, 1 bit: the single clock; all logic SHALL be clocked on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 Port button, input, 1 bit: raw asynchronous push-button, high = pressed.
REQ-006 Port btn_level, output, 1 bit: debounced button level, registered; suitable for the downstream LED counter's button input.
REQ-007 Port press_pulse, output, 1 bit: one-cycle strobe on accepted press.
REQ-008 Port release_pulse, output, 1 bit: one-cycle strobe on accepted release.
REQ-009 Port long_pulse, output, 1 bit: one-cycle strobe on long press.

Function
REQ-010 button SHALL pass through a two-flop synchronizer (s1, s2); the FSM SHALL use only s2.
REQ-011 FSM states SHALL be IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT.
REQ-012 IDLE: s2=1 -> PRESS_WAIT with debounce count=1; else stay.
REQ-013 PRESS_WAIT: s2=0 -> IDLE, count cleared, no pulse; s2=1 and count=DEBOUNCE_CYCLES-1 -> PRESSED with btn_level=1 and press_pulse=1 for that cycle; otherwise count+1.
REQ-014 PRESSED: s2=0 -> RELEASE_WAIT with count=1; else stay.
REQ-015 RELEASE_WAIT: s2=1 -> PRESSED, count cleared, no pulse, btn_level stays 1; s2=0 and count=DEBOUNCE_CYCLES-1 -> IDLE with btn_level=0 and release_pulse=1; otherwise count+1.
REQ-016 Latency: with button stable, btn_level and press_pulse SHALL register high at edge DEBOUNCE_CYCLES+1, counting the edge that first samples button=1 as edge 0; release symmetric.
REQ-017 Debounce counter width SHALL be $clog2(DEBOUNCE_CYCLES+1) bits and SHALL never wrap.
REQ-018 press_pulse, release_pulse and long_pulse SHALL each be high for exactly one cycle per event and never simultaneously.
REQ-019 Any glitch shorter than DEBOUNCE_CYCLES synchronized samples SHALL produce no output change.

Reset
REQ-020 While rst=1 at a clock edge: state=IDLE, s1=s2=0, all counters=0, btn_level=press_pulse=release_pulse=long_pulse=0.
REQ-021 Reset mid-operation (any state) SHALL abort without emitting any pulse; a button held through reset SHALL be re-debounced as a new press after rst falls.

Configuration
REQ-022 Macro LONG_PRESS_EN defined: a hold counter ($clog2(LONG_PRESS_CYCLES+1) bits) SHALL clear on entering PRESSED, increment each cycle in PRESSED or RELEASE_WAIT, saturate at LONG_PRESS_CYCLES, and fire long_pulse once on the cycle it reaches LONG_PRESS_CYCLES; no repeat until a new press.
REQ-023 Macro LONG_PRESS_EN undefined: hold counter SHALL be absent and long_pulse SHALL be constant 0; all other behaviour identical.

Structure
REQ-024 Package button_debounce_pkg SHALL hold the FSM state typedef (2-bit enum) and default parameter constants.
REQ-025 Synchronizer SHALL be sub-module sync_2ff (1-bit, clk/rst, reset value 0).

Verification (DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=10)
REQ-026 Clean press: button 0->1 held, first sampled at edge 0 -> btn_level=1 and press_pulse=1 after edge 5, press_pulse 0 after edge 6.
REQ-027 Bounce: button 1 for 2 cycles, 0 for 1, then 1 held -> no pulse for the glitch; exactly one press_pulse, btn_level rises 4 samples after final stable high.
REQ-028 Release glitch: while PRESSED, button 0 for 3 cycles then 1 -> btn_level stays 1, no release_pulse; then 0 held -> one release_pulse, btn_level=0.
REQ-029 Long press (LONG_PRESS_EN): hold 20 cycles after press_pulse -> exactly one long_pulse, 10 cycles after press_pulse; without macro long_pulse stays 0.
REQ-030 Reset mid-debounce: rst=1 in PRESS_WAIT with button held -> all outputs 0 after that edge; after rst falls, press_pulse after edge 5 relative to first post-reset sample.

Source files
------------

// File: rtl/button_debounce_pkg.sv
// button_debounce_pkg: FSM state type and default parameters for button_debounce.
package button_debounce_pkg;
  typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;
  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_LONG_PRESS_CYCLES = 50000000;
endpackage

// File: rtl/button_debounce_sync_2ff.sv
// sync_2ff: two-flop synchronizer for one asynchronous bit, resets to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic s1;
  always_ff @(posedge clk)
    if (rst) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
endmodule

// File: rtl/button_debounce.sv
// button_debounce: synchronized push-button debouncer with press/release strobes;
// define LONG_PRESS_EN to add the long-press hold counter and long_pulse strobe.
module button_debounce
  import button_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic button,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic s2;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic level_n, press_n, release_n;
  sync_2ff u_sync (.clk(clk), .rst(rst), .d(button), .q(s2));
  always_ff @(posedge clk)
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      btn_level     <= level_n;
      press_pulse   <= press_n;
      release_pulse <= release_n;
    end
  // the count restarts at 1 because the first differing sample already counts
  always_comb begin
    state_n = state;
    cnt_n   = '0;
    case (state)
      IDLE: begin
        state_n = s2 ? PRESS_WAIT : IDLE;
        cnt_n   = CW'(s2);
      end
      PRESS_WAIT:
        if (!s2) state_n = IDLE;
        else if (cnt == LAST) state_n = PRESSED;
        else cnt_n = cnt + 1'b1;
      PRESSED: begin
        state_n = s2 ? PRESSED : RELEASE_WAIT;
        cnt_n   = CW'(!s2);
      end
      RELEASE_WAIT:
        if (s2) state_n = PRESSED;
        else if (cnt == LAST) state_n = IDLE;
        else cnt_n = cnt + 1'b1;
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    press_n   = state == PRESS_WAIT && state_n == PRESSED;
    release_n = state == RELEASE_WAIT && state_n == IDLE;
    level_n   = state_n == PRESSED || state_n == RELEASE_WAIT;
  end
`ifdef LONG_PRESS_EN
  localparam int HW = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [HW-1:0] HMAX = HW'(LONG_PRESS_CYCLES);
  localparam logic [HW-1:0] HFIRE = HW'(LONG_PRESS_CYCLES - 1);
  logic [HW-1:0] hold;
  logic holding;
  assign holding = state == PRESSED || state == RELEASE_WAIT;
  // cleared only on a fresh press so a release glitch cannot re-arm the strobe
  always_ff @(posedge clk)
    if (rst || press_n) hold <= '0;
    else if (holding && hold != HMAX) hold <= hold + 1'b1;
  always_ff @(posedge clk)
    if (rst) long_pulse <= 1'b0;
    else long_pulse <= holding && hold == HFIRE && !release_n;
`else
  logic unused_long;
  assign unused_long = ^LONG_PRESS_CYCLES;
  assign long_pulse = 1'b0;
`endif
endmodule

// File: tb/tb_button_debounce.sv
// tb_button_debounce: directed self-checking bench for button_debounce (D=4, L=10).
module tb_button_debounce;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic button = 1'b0;
  logic btn_level, press_pulse, release_pulse, long_pulse;
  int checks = 0;
  int failures = 0;
  button_debounce #(.DEBOUNCE_CYCLES(4), .LONG_PRESS_CYCLES(10)) dut (
    .clk(clk), .rst(rst), .button(button), .btn_level(btn_level),
    .press_pulse(press_pulse), .release_pulse(release_pulse), .long_pulse(long_pulse)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    button = 1'b0;
    tick();
    tick();
    checks++;
    if ({btn_level, press_pulse, release_pulse, long_pulse} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_outputs got=%b want=0000", {btn_level, press_pulse, release_pulse, long_pulse});
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({btn_level, press_pulse} !== 2'b00) begin
      failures++;
      $display("FAIL idle_after_reset got=%b want=00", {btn_level, press_pulse});
    end
  endtask
  task automatic test_clean_press();
    button = 1'b1;
    for (int i = 0; i <= 4; i++) begin
      tick();
      checks++;
      if ({btn_level, press_pulse} !== 2'b00) begin
        failures++;
        $display("FAIL press_early edge=%0d got=%b want=00", i, {btn_level, press_pulse});
      end
    end
    tick();
    checks++;
    if ({btn_level, press_pulse} !== 2'b11) begin
      failures++;
      $display("FAIL press_edge5 got=%b want=11", {btn_level, press_pulse});
    end
    tick();
    checks++;
    if ({btn_level, press_pulse} !== 2'b10) begin
      failures++;
      $display("FAIL press_edge6 got=%b want=10", {btn_level, press_pulse});
    end
    button = 1'b0;
    for (int i = 0; i <= 4; i++) begin
      tick();
      checks++;
      if ({btn_level, release_pulse} !== 2'b10) begin
        failures++;
        $display("FAIL release_early edge=%0d got=%b want=10", i, {btn_level, release_pulse});
      end
    end
    tick();
    checks++;
    if ({btn_level, release_pulse} !== 2'b01) begin
      failures++;
      $display("FAIL release_edge5 got=%b want=01", {btn_level, release_pulse});
    end
    tick();
    checks++;
    if ({btn_level, release_pulse, long_pulse} !== 3'b000) begin
      failures++;
      $display("FAIL release_edge6 got=%b want=000", {btn_level, release_pulse, long_pulse});
    end
  endtask
  task automatic test_bounce();
    int pulses = 0;
    int rise = -1;
    for (int t = 0; t < 16; t++) begin
      button = (t != 2);
      tick();
      if (press_pulse) pulses++;
      if (btn_level && rise < 0) rise = t;
    end
    checks++;
    if (pulses !== 1) begin
      failures++;
      $display("FAIL bounce_pulses got=%0d want=1", pulses);
    end
    checks++;
    if (rise !== 8) begin
      failures++;
      $display("FAIL bounce_rise_tick got=%0d want=8", rise);
    end
  endtask
  task automatic test_release_glitch();
    int rel = 0;
    int low = 0;
    for (int t = 0; t < 12; t++) begin
      button = (t >= 3);
      tick();
      if (release_pulse) rel++;
      if (!btn_level) low++;
    end
    checks++;
    if (rel !== 0 || low !== 0) begin
      failures++;
      $display("FAIL release_glitch got rel=%0d low=%0d want 0 0", rel, low);
    end
    button = 1'b0;
    rel = 0;
    for (int t = 0; t < 12; t++) begin
      tick();
      if (release_pulse) rel++;
    end
    checks++;
    if (rel !== 1 || btn_level !== 1'b0) begin
      failures++;
      $display("FAIL release_after_glitch got rel=%0d level=%b want 1 0", rel, btn_level);
    end
  endtask
  task automatic test_long_press();
    int longs = 0;
    int at = -1;
    int seen = 0;
    button = 1'b1;
    for (int t = 0; t < 20 && !seen; t++) begin
      tick();
      if (press_pulse) seen = 1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL long_press_timeout got=no_press want=press_pulse");
    end
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (long_pulse) begin
        longs++;
        if (at < 0) at = i;
      end
      if (long_pulse && (press_pulse || release_pulse)) longs += 100;
    end
`ifdef LONG_PRESS_EN
    checks++;
    if (longs !== 1 || at !== 10) begin
      failures++;
      $display("FAIL long_pulse got count=%0d at=%0d want 1 at 10", longs, at);
    end
`else
    checks++;
    if (longs !== 0) begin
      failures++;
      $display("FAIL long_pulse_disabled got=%0d want=0", longs);
    end
`endif
    button = 1'b0;
    for (int t = 0; t < 8; t++) tick();
    checks++;
    if (btn_level !== 1'b0) begin
      failures++;
      $display("FAIL long_release got=%b want=0", btn_level);
    end
  endtask
  task automatic test_reset_mid();
    button = 1'b1;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if ({btn_level, press_pulse, release_pulse, long_pulse} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_mid_outputs got=%b want=0000", {btn_level, press_pulse, release_pulse, long_pulse});
    end
    rst = 1'b0;
    for (int i = 0; i <= 4; i++) begin
      tick();
      checks++;
      if ({btn_level, press_pulse} !== 2'b00) begin
        failures++;
        $display("FAIL reset_mid_early edge=%0d got=%b want=00", i, {btn_level, press_pulse});
      end
    end
    tick();
    checks++;
    if ({btn_level, press_pulse} !== 2'b11) begin
      failures++;
      $display("FAIL reset_mid_press got=%b want=11", {btn_level, press_pulse});
    end
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if ({btn_level, press_pulse, release_pulse} !== 3'b000) begin
      failures++;
      $display("FAIL reset_pressed got=%b want=000", {btn_level, press_pulse, release_pulse});
    end
    rst = 1'b0;
    button = 1'b0;
    tick();
  endtask
  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_release_glitch();
    test_long_press();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
